// File: rtl/wishbone_arbiter_n.sv
// N-master round-robin Wishbone arbiter with a stall watchdog.
// A grant is held for the master's whole cyc assertion. A stalled strobe ends the transfer with an err pulse.
module wishbone_arbiter_n #(
    parameter int NM     = 4,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2,
    parameter int TMO_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NM-1:0]        m_cyc,
    input  logic [NM-1:0]        m_stb,
    input  logic [NM-1:0]        m_we,
    input  logic [NM-1:0]        m_4_burst,
    input  logic [NM-1:0]        m_8_burst,
    input  logic [NM*ADDR_W-1:0] m_adr,
    input  logic [NM*DATA_W-1:0] m_o_dat,
    input  logic [NM*SEL_W-1:0]  m_sel,
    output logic [NM-1:0]        m_ack,
    output logic [NM-1:0]        m_err,
    output logic [DATA_W-1:0]    m_i_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic                 o_wb_4_burst,
    output logic                 o_wb_8_burst,
    output logic [ADDR_W-1:0]    o_wb_adr,
    output logic [DATA_W-1:0]    o_wb_o_dat,
    output logic [SEL_W-1:0]     o_wb_sel,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    input  logic [DATA_W-1:0]    i_wb_i_dat,
    output logic [NM-1:0]        o_grant
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    rr_win;
    logic             stalled;

    assign m_i_dat = i_wb_i_dat;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NM - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Round-robin search starting just past the most recent grant.
    always_comb begin : rr_search
        logic [GW-1:0] idx;
        logic          found;
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        idx    = '0;
        found  = 1'b0;
        rr_win = last_grant_q;
        for (int i = 1; i <= NM; i++) begin
            idx = GW'((int'(last_grant_q) + i) % NM);
            if (!found && m_cyc[idx]) begin
                found  = 1'b1;
                rr_win = idx;
            end
        end
    end

    assign stalled = m_stb[last_grant_q] && !i_wb_ack && !i_wb_err;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = '0;
        o_wb_cyc     = 1'b0;
        o_wb_stb     = 1'b0;
        o_wb_we      = 1'b0;
        o_wb_4_burst = 1'b0;
        o_wb_8_burst = 1'b0;
        o_wb_adr     = '0;
        o_wb_o_dat   = '0;
        o_wb_sel     = '0;
        m_ack        = '0;
        m_err        = '0;
        o_grant      = '0;

        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_d      = ST_BUSY;
                    last_grant_d = rr_win;
                end
            end

            ST_BUSY: begin
                o_grant[last_grant_q] = 1'b1;
                o_wb_cyc     = m_cyc[last_grant_q];
                o_wb_stb     = m_stb[last_grant_q];
                o_wb_we      = m_we[last_grant_q];
                o_wb_4_burst = m_4_burst[last_grant_q];
                o_wb_8_burst = m_8_burst[last_grant_q];
                o_wb_adr     = m_adr[last_grant_q*ADDR_W +: ADDR_W];
                o_wb_o_dat   = m_o_dat[last_grant_q*DATA_W +: DATA_W];
                o_wb_sel     = m_sel[last_grant_q*SEL_W +: SEL_W];
                m_ack[last_grant_q] = i_wb_ack;
                m_err[last_grant_q] = i_wb_err;

                if (!m_cyc[last_grant_q]) begin
                    state_d = ST_IDLE;
                end else if (stalled) begin
                    // Timeout fires on the stalled cycle that brings the count to its maximum.
                    if (cnt_q == CNT_MAX - 1'b1) begin
                        m_err[last_grant_q] = 1'b1;
                        state_d             = ST_ABORT;
                    end else begin
                        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                    end
                end
            end

            ST_ABORT: begin
                o_grant[last_grant_q] = 1'b1;
                if (!m_cyc[last_grant_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter_n.sv
// Directed bench for wishbone_arbiter_n: a per-cycle vector table followed by
// burst, watchdog, ack-vs-timeout and mid-transfer reset sequences.
module tb_wishbone_arbiter_n;

    localparam int NM = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int TW = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic [NM-1:0]  m_cyc, m_stb, m_we, m_4_burst, m_8_burst;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_o_dat;
    logic [NM*SW-1:0] m_sel;
    logic [NM-1:0]  m_ack, m_err;
    logic [DW-1:0]  m_i_dat;
    logic           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst;
    logic [AW-1:0]  o_wb_adr;
    logic [DW-1:0]  o_wb_o_dat;
    logic [SW-1:0]  o_wb_sel;
    logic           i_wb_ack, i_wb_err;
    logic [DW-1:0]  i_wb_i_dat;
    logic [NM-1:0]  o_grant;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    wishbone_arbiter_n #(
        .NM(NM), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TMO_W(TW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_4_burst(m_4_burst), .m_8_burst(m_8_burst),
        .m_adr(m_adr), .m_o_dat(m_o_dat), .m_sel(m_sel),
        .m_ack(m_ack), .m_err(m_err), .m_i_dat(m_i_dat),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_4_burst(o_wb_4_burst), .o_wb_8_burst(o_wb_8_burst),
        .o_wb_adr(o_wb_adr), .o_wb_o_dat(o_wb_o_dat), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_i_dat(i_wb_i_dat),
        .o_grant(o_grant)
    );

    typedef struct {
        logic [3:0] cyc;
        logic [3:0] stb;
        logic       ack;
        logic       err;
        logic [3:0] grant;
        logic       bus;
        logic [3:0] mack;
        logic [3:0] merr;
    } vec_t;

    vec_t vecs [25];

    function automatic logic [AW-1:0] adr_of(input int k);
        return 24'h5A0000 + 24'(k) * 24'h000111;
    endfunction

    function automatic logic [DW-1:0] dat_of(input int k);
        return 16'hD000 + 16'(k) * 16'h0101;
    endfunction

    function automatic int oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave side must mirror master k when bus=1, and be all-zero otherwise.
    task automatic check_bus(input string tag, input logic bus, input int k);
        check({tag, ".cyc"}, 32'(o_wb_cyc),     32'(bus & m_cyc[k]));
        check({tag, ".stb"}, 32'(o_wb_stb),     32'(bus & m_stb[k]));
        check({tag, ".we"},  32'(o_wb_we),      32'(bus & m_we[k]));
        check({tag, ".b4"},  32'(o_wb_4_burst), 32'(bus & m_4_burst[k]));
        check({tag, ".b8"},  32'(o_wb_8_burst), 32'(bus & m_8_burst[k]));
        check({tag, ".adr"}, 32'(o_wb_adr),     bus ? 32'(adr_of(k)) : 32'h0);
        check({tag, ".dat"}, 32'(o_wb_o_dat),   bus ? 32'(dat_of(k)) : 32'h0);
        check({tag, ".sel"}, 32'(o_wb_sel),     bus ? 32'(k % 4) : 32'h0);
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic a, input logic e);
        m_cyc    = c;
        m_stb    = s;
        i_wb_ack = a;
        i_wb_err = e;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        m_we      = 4'b1010;
        m_4_burst = 4'b0101;
        m_8_burst = 4'b0110;
        for (int k = 0; k < NM; k++) begin
            m_adr[k*AW +: AW]   = adr_of(k);
            m_o_dat[k*DW +: DW] = dat_of(k);
            m_sel[k*SW +: SW]   = SW'(k);
        end
        i_wb_i_dat = 16'hBEEF;

        //                 cyc      stb      ack   err   grant    bus   mack     merr
        vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000};
        vecs[3]  = '{4'b1110, 4'b1110, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        vecs[6]  = '{4'b1101, 4'b1101, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0100};
        vecs[9]  = '{4'b1011, 4'b1011, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[11] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000};
        vecs[12] = '{4'b0111, 4'b0111, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0000, 4'b0000};
        vecs[13] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[14] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000};
        vecs[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000};
        vecs[16] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[17] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000};
        vecs[18] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000};
        vecs[19] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000};
        vecs[20] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000};
        vecs[21] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[22] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
        vecs[23] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
        vecs[24] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};

        // Held in reset with every master requesting and the slave responding.
        drive(4'b1111, 4'b1111, 1'b1, 1'b1);
        #12;
        check("rst.grant", 32'(o_grant), 32'h0);
        check("rst.ack",   32'(m_ack),   32'h0);
        check("rst.err",   32'(m_err),   32'h0);
        check_bus("rst", 1'b0, 0);
        next_cycle();
        i_rst = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Round-robin, single-requester, stb-low hold and ack/err routing.
        for (int i = 0; i < 25; i++) begin
            next_cycle();
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].err);
            i_wb_i_dat = 16'h1000 + 16'(i);
            #2;
            check($sformatf("v%0d.grant", i), 32'(o_grant), 32'(vecs[i].grant));
            check($sformatf("v%0d.ack", i),   32'(m_ack),   32'(vecs[i].mack));
            check($sformatf("v%0d.err", i),   32'(m_err),   32'(vecs[i].merr));
            check($sformatf("v%0d.idat", i),  32'(m_i_dat), 32'(16'h1000 + 16'(i)));
            check_bus($sformatf("v%0d", i), vecs[i].bus, oh_idx(vecs[i].grant));
        end

        // Master 1 runs an 8-beat burst; master 0 waits until it is released.
        next_cycle();
        drive(4'b0010, 4'b0010, 1'b0, 1'b0);
        #2;
        check("bst.idle", 32'(o_grant), 32'h0);
        for (int b = 0; b < 8; b++) begin
            next_cycle();
            drive(4'b0011, 4'b0011, 1'b1, 1'b0);
            #2;
            check($sformatf("bst%0d.grant", b), 32'(o_grant), 32'b0010);
            check($sformatf("bst%0d.ack", b),   32'(m_ack),   32'b0010);
            check_bus($sformatf("bst%0d", b), 1'b1, 1);
        end
        next_cycle();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        #2;
        check("bst.rel.grant", 32'(o_grant), 32'b0010);
        check("bst.rel.cyc",   32'(o_wb_cyc), 32'h0);
        next_cycle();
        #2;
        check("bst.gap", 32'(o_grant), 32'h0);

        // Master 0 now stalls: err at the 15th stalled cycle, then ABORT.
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            #2;
            check($sformatf("tmo%0d.grant", c), 32'(o_grant), 32'b0001);
            check($sformatf("tmo%0d.stb", c),   32'(o_wb_stb), 32'h1);
            check($sformatf("tmo%0d.err", c),   32'(m_err), (c == 15) ? 32'b0001 : 32'h0);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(4'b0001, 4'b0001, 1'b1, 1'b1);
            #2;
            check($sformatf("abt%0d.grant", c), 32'(o_grant), 32'b0001);
            check($sformatf("abt%0d.ack", c),   32'(m_ack), 32'h0);
            check($sformatf("abt%0d.err", c),   32'(m_err), 32'h0);
            check_bus($sformatf("abt%0d", c), 1'b0, 0);
        end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        #2;
        check("abt.rel.grant", 32'(o_grant), 32'b0001);
        next_cycle();
        #2;
        check("abt.idle", 32'(o_grant), 32'h0);

        // Master 3: ack lands on the cycle the watchdog would fire.
        next_cycle();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        #2;
        check("race.idle", 32'(o_grant), 32'h0);
        for (int c = 1; c <= 29; c++) begin
            next_cycle();
            drive(4'b1000, 4'b1000, (c == 15), 1'b0);
            #2;
            check($sformatf("race%0d.grant", c), 32'(o_grant), 32'b1000);
            check($sformatf("race%0d.err", c),   32'(m_err), 32'h0);
            check($sformatf("race%0d.ack", c),   32'(m_ack), (c == 15) ? 32'b1000 : 32'h0);
        end
        next_cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        next_cycle();
        #2;
        check("race.end", 32'(o_grant), 32'h0);

        // Reset in the middle of a master-1 transfer.
        next_cycle();
        drive(4'b0110, 4'b0110, 1'b0, 1'b0);
        next_cycle();
        #2;
        check("mrst.pre.grant", 32'(o_grant), 32'b0010);
        next_cycle();
        drive(4'b1111, 4'b1111, 1'b1, 1'b1);
        #1;
        check("mrst.busy.ack", 32'(m_ack), 32'b0010);
        i_rst = 1'b0;
        #1;
        check("mrst.async.grant", 32'(o_grant), 32'h0);
        check("mrst.async.ack",   32'(m_ack),   32'h0);
        check("mrst.async.err",   32'(m_err),   32'h0);
        check_bus("mrst.async", 1'b0, 0);
        next_cycle();
        #2;
        check("mrst.hold.grant", 32'(o_grant), 32'h0);
        check("mrst.hold.cyc",   32'(o_wb_cyc), 32'h0);
        i_rst = 1'b1;
        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        #2;
        check("mrst.idle", 32'(o_grant), 32'h0);
        next_cycle();
        #2;
        check("mrst.first.grant", 32'(o_grant), 32'b0001);
        check_bus("mrst.first", 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_arbiter_n.md
WISHBONE_ARBITER_N -- requirements
Module: wishbone_arbiter_n

Interface
REQ-001 Parameter NM, default 4: number of master ports; legal range 2..8.
REQ-002 Parameter ADDR_W, default 24: Wishbone address width.
REQ-003 Parameter DATA_W, default 16: Wishbone data width.
REQ-004 Parameter SEL_W, default 2: byte-select width.
REQ-005 Parameter TMO_W, default 8: watchdog counter width; timeout fires at 2^TMO_W-1 stalled cycles.
REQ-006 Port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port i_rst, input, 1: reset, asynchronous assert, active-low (0 = reset).
REQ-008 Ports m_cyc, m_stb, m_we, m_4_burst, m_8_burst, input, NM each: per-master control; bit k = master k.
REQ-009 Ports m_adr, m_o_dat, m_sel, input, NM*ADDR_W / NM*DATA_W / NM*SEL_W: flattened per-master buses; slice k = master k.
REQ-010 Ports m_ack, m_err, output, NM each: per-master response strobes.
REQ-011 Port m_i_dat, output, DATA_W: slave read data, broadcast to all masters.
REQ-012 Ports o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst, output, 1 each: slave-side control.
REQ-013 Ports o_wb_adr, o_wb_o_dat, o_wb_sel, output, ADDR_W / DATA_W / SEL_W: slave-side buses.
REQ-014 Ports i_wb_ack, i_wb_err, i_wb_i_dat, input, 1 / 1 / DATA_W: slave response.
REQ-015 Port o_grant, output, NM: one-hot current grant, all-zero when idle, for debug.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, ABORT.
REQ-017 In IDLE, if any m_cyc bit is 1, the arbiter SHALL grant one master and enter BUSY on the next edge.
REQ-018 The grant SHALL be round-robin: search starts at index (last_grant+1) mod NM and takes the first set m_cyc bit. After reset, last_grant SHALL be NM-1, so master 0 has first priority.
REQ-019 Grant latency SHALL be exactly 1 cycle: master cyc is seen in IDLE at cycle t, and the slave bus carries that master from cycle t+1.
REQ-020 In BUSY, all slave-side outputs SHALL equal the granted master's signals, combinationally.
REQ-021 In BUSY, i_wb_ack and i_wb_err SHALL route only to the granted master's m_ack / m_err bit; all other bits SHALL be 0.
REQ-022 In BUSY, when the granted master's m_cyc is 0, the FSM SHALL return to IDLE and o_wb_cyc SHALL be 0 in that same cycle. There is one mandatory idle cycle before the next grant.
REQ-023 In IDLE and ABORT, all slave-side outputs SHALL be 0, and all m_ack / m_err bits SHALL be 0 except as stated in REQ-025.
REQ-024 Watchdog: a TMO_W-bit counter SHALL increment each BUSY cycle with o_wb_stb=1 and no ack or err. It SHALL clear on ack, err, stb=0, or leaving BUSY. It SHALL saturate and never wrap.
REQ-025 When the counter reaches 2^TMO_W-1, the arbiter SHALL pulse the granted master's m_err for exactly 1 cycle and enter ABORT. Slave-side outputs SHALL be forced to 0 from the cycle after the pulse.
REQ-026 ABORT SHALL hold the grant, ignore i_wb_ack and i_wb_err, and return to IDLE once the granted master's m_cyc is 0.
REQ-027 Simultaneous ack and timeout in the same cycle: the ack SHALL win; no err is issued and the counter clears.
REQ-028 Simultaneous i_wb_ack and i_wb_err: both SHALL be forwarded unchanged; priority is the master's concern.
REQ-029 Burst qualifiers SHALL pass through unmodified. The grant SHALL be held for the granted master's full cyc assertion, so bursts are never split.
REQ-030 A master dropping cyc while not granted SHALL have no effect. A granted master's stb=0 with cyc=1 SHALL keep the grant.

Reset
REQ-031 While i_rst=0: FSM=IDLE, last_grant=NM-1, counter=0, o_grant=0, all slave-side outputs 0, all m_ack / m_err bits 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no err pulse. The first grant after release SHALL follow REQ-018.

Verification
REQ-033 NM=4; m_cyc=4'b1111 held, each grant released after 1 ack -> grants 0,1,2,3,0, with one idle cycle between grants.
REQ-034 Master 2 only requests at cycle t -> o_wb_cyc=1 with o_wb_adr = master 2's address at t+1; o_grant=4'b0100.
REQ-035 Master 1 holds an 8-beat burst while master 0 requests -> master 0 receives no grant until master 1 drops cyc after the 8th ack.
REQ-036 TMO_W=4, slave never acks -> m_err of the granted master pulses at the 15th stalled cycle; o_wb_stb=0 next cycle; ABORT until that master's cyc=0.
REQ-037 Ack arrives in the same cycle the counter hits 15 -> ack delivered, no err, counter 0.
REQ-038 i_rst pulsed low during BUSY -> all outputs 0 asynchronously; after release, master 0 wins if all request.
